ddr4_cmd_gen: RTL and testbench

Single-rank DDR4 command generator sitting directly upstream of the DIMM model. Accepts one column-level read/write request at a time and drives the DIMM command/address pins (act_n, A, bg, ba, cs_n, cke) with the correct ACT/PRE/RD/WR/REF sequence. Enforces tRCD, tRP, tRAS, tRFC, tREFI and burst spacing with counters. Keeps an open-page table per bank.

---
 rtl/ddr4_pkg.sv | 34 +++
 rtl/ddr4_bank_table.sv | 73 +++++++
 rtl/ddr4_cmd_gen.sv | 256 +++++++++++++++++++++++++
 tb/tb_ddr4_cmd_gen.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr4_pkg.sv
// Shared types and constants for the DDR4 command generator: FSM states, A[16:14]
// command codes and the bank index helper.
package ddr4_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StPre,
        StWaitRp,
        StAct,
        StWaitRcd,
        StCas,
        StWaitBurst,
        StPrea,
        StWaitRpa,
        StRef,
        StWaitRfc
    } state_t;

    // {ras_n, cas_n, we_n} as carried on A[16:14]
    localparam logic [2:0] CmdRd  = 3'b101;
    localparam logic [2:0] CmdWr  = 3'b100;
    localparam logic [2:0] CmdPre = 3'b010;
    localparam logic [2:0] CmdRef = 3'b001;

    localparam int unsigned CmdMsb = 16;
    localparam int unsigned CmdLsb = 14;
    localparam int unsigned ApBit  = 10;

    function automatic int unsigned bank_idx(input int unsigned bg, input int unsigned ba,
                                             input int unsigned ba_width);
        return (bg << ba_width) | ba;
    endfunction

endpackage

// File: rtl/ddr4_bank_table.sv
// Per-bank open-page table: open flag, open row and a tRAS hold-off down-counter that
// is reloaded whenever the bank is activated.
module ddr4_bank_table #(
    parameter int unsigned NumBanks = 16,
    parameter int unsigned IdxW     = 4,
    parameter int unsigned RowW     = 17,
    parameter int unsigned tRAS     = 10
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [IdxW-1:0] i_idx,
    output logic            o_open,
    output logic [RowW-1:0] o_row,
    output logic            o_tras_met,
    input  logic            i_act,
    input  logic [RowW-1:0] i_act_row,
    input  logic            i_close,
    input  logic            i_close_all,
    output logic            o_all_tras_met,
    output logic            o_any_open
);

    localparam int unsigned TrasW = $clog2(tRAS);

    logic [NumBanks-1:0] r_open;
    logic [RowW-1:0]     r_row  [NumBanks];
    logic [TrasW-1:0]    r_tras [NumBanks];
    logic                w_all_met;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_open <= '0;
            for (int i = 0; i < NumBanks; i++) begin
                r_row[i]  <= '0;
                r_tras[i] <= '0;
            end
        end else begin
            // Loading tRAS-1 lets a PRE decided in the cycle the count hits zero land
            // exactly tRAS cycles after the ACT.
            for (int i = 0; i < NumBanks; i++) begin
                if (i_act && (i_idx == IdxW'(i))) begin
                    r_tras[i] <= TrasW'(tRAS - 1);
                end else if (r_tras[i] != '0) begin
                    r_tras[i] <= r_tras[i] - 1'b1;
                end
            end
            if (i_close_all) begin
                r_open <= '0;
            end else if (i_close) begin
                r_open[i_idx] <= 1'b0;
            end else if (i_act) begin
                r_open[i_idx] <= 1'b1;
                r_row[i_idx]  <= i_act_row;
            end
        end
    end

    always_comb begin
        w_all_met = 1'b1;
        for (int i = 0; i < NumBanks; i++) begin
            if (r_open[i] && (r_tras[i] != '0)) begin
                w_all_met = 1'b0;
            end
        end
    end

    assign o_open         = r_open[i_idx];
    assign o_row          = r_row[i_idx];
    assign o_tras_met     = (r_tras[i_idx] == '0);
    assign o_all_tras_met = w_all_met;
    assign o_any_open     = |r_open;

endmodule

// File: rtl/ddr4_cmd_gen.sv
// Single-rank DDR4 command generator: sequences ACT/PRE/RD/WR/PREA/REF for one request
// at a time with counter-enforced timing and periodic refresh.
module ddr4_cmd_gen
    import ddr4_pkg::*;
#(
    parameter int unsigned BGWIDTH   = 2,
    parameter int unsigned BAWIDTH   = 2,
    parameter int unsigned ADDRWIDTH = 17,
    parameter int unsigned COLWIDTH  = 10,
    parameter int unsigned BL        = 8,
    parameter int unsigned tRCD      = 4,
    parameter int unsigned tRP       = 4,
    parameter int unsigned tRAS      = 10,
    parameter int unsigned tRFC      = 20,
    parameter int unsigned tREFI     = 200
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_rd_o_wr,
    input  logic [BGWIDTH-1:0]   req_bg,
    input  logic [BAWIDTH-1:0]   req_ba,
    input  logic [ADDRWIDTH-1:0] req_row,
    input  logic [COLWIDTH-1:0]  req_col,
    output logic                 cmd_done,
    output logic                 act_n,
    output logic                 cs_n,
    output logic                 cke,
    output logic [ADDRWIDTH-1:0] A,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba
);

    localparam int unsigned IdxW     = BGWIDTH + BAWIDTH;
    localparam int unsigned NumBanks = 1 << IdxW;
    localparam int unsigned WaitW    = $clog2(tRFC + tRCD + tRP + BL);
    localparam int unsigned RefW     = $clog2(tREFI + 1);

    state_t               r_state, w_state_next;
    logic [WaitW-1:0]     r_wait, w_wait_next;
    logic [RefW-1:0]      r_ref_cnt;
    logic                 r_ref_pending;

    logic                 r_req_rd;
    logic [BGWIDTH-1:0]   r_req_bg;
    logic [BAWIDTH-1:0]   r_req_ba;
    logic [ADDRWIDTH-1:0] r_req_row;
    logic [COLWIDTH-1:0]  r_req_col;

    logic                 r_act_n, r_cs_n, r_cke, r_cmd_done;
    logic [ADDRWIDTH-1:0] r_a;
    logic [BGWIDTH-1:0]   r_bg;
    logic [BAWIDTH-1:0]   r_ba;

    logic                 w_act_n, w_cs_n, w_cmd_done;
    logic [ADDRWIDTH-1:0] w_a;
    logic [BGWIDTH-1:0]   w_bg;
    logic [BAWIDTH-1:0]   w_ba;

    logic                 w_ref_due, w_ready, w_accept, w_ref_clear;
    logic [IdxW-1:0]      w_req_idx, w_cur_idx, w_tbl_idx;
    logic                 w_tbl_open, w_tbl_tras_met, w_tbl_all_tras_met, w_tbl_any_open;
    logic                 w_tbl_act, w_tbl_close, w_tbl_close_all;
    logic [ADDRWIDTH-1:0] w_tbl_row;

    assign w_req_idx = IdxW'(bank_idx(32'(req_bg), 32'(req_ba), BAWIDTH));
    assign w_cur_idx = IdxW'(bank_idx(32'(r_req_bg), 32'(r_req_ba), BAWIDTH));
    // Lookup happens on the incoming request in IDLE, on the latched one afterwards.
    assign w_tbl_idx = (r_state == StIdle) ? w_req_idx : w_cur_idx;

    // The counter never rests at zero: the cycle it would reach zero is the due cycle.
    assign w_ref_due = (r_ref_cnt == RefW'(1));
    assign w_ready   = (r_state == StIdle) && !r_ref_pending && !w_ref_due && r_cke;
    assign w_accept  = req_valid && w_ready;

    ddr4_bank_table #(
        .NumBanks(NumBanks),
        .IdxW    (IdxW),
        .RowW    (ADDRWIDTH),
        .tRAS    (tRAS)
    ) u_bank_table (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_idx         (w_tbl_idx),
        .o_open        (w_tbl_open),
        .o_row         (w_tbl_row),
        .o_tras_met    (w_tbl_tras_met),
        .i_act         (w_tbl_act),
        .i_act_row     (r_req_row),
        .i_close       (w_tbl_close),
        .i_close_all   (w_tbl_close_all),
        .o_all_tras_met(w_tbl_all_tras_met),
        .o_any_open    (w_tbl_any_open)
    );

    always_comb begin
        w_state_next    = r_state;
        w_wait_next     = r_wait;
        w_cs_n          = 1'b1;
        w_act_n         = 1'b1;
        w_a             = '0;
        w_bg            = '0;
        w_ba            = '0;
        w_cmd_done      = 1'b0;
        w_tbl_act       = 1'b0;
        w_tbl_close     = 1'b0;
        w_tbl_close_all = 1'b0;
        w_ref_clear     = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (r_ref_pending || w_ref_due) begin
                    w_state_next = w_tbl_any_open ? StPrea : StRef;
                end else if (w_accept) begin
                    if (!w_tbl_open) begin
                        w_state_next = StAct;
                    end else if (w_tbl_row == req_row) begin
                        w_state_next = StCas;
                    end else begin
                        w_state_next = StPre;
                    end
                end
            end
            StPre: begin
                if (w_tbl_tras_met) begin
                    w_cs_n                = 1'b0;
                    w_a[CmdMsb:CmdLsb]    = CmdPre;
                    w_bg                  = r_req_bg;
                    w_ba                  = r_req_ba;
                    w_tbl_close           = 1'b1;
                    w_wait_next           = WaitW'(tRP - 2);
                    w_state_next          = StWaitRp;
                end
            end
            StWaitRp: begin
                if (r_wait == '0) w_state_next = StAct;
                else              w_wait_next  = r_wait - 1'b1;
            end
            StAct: begin
                w_cs_n       = 1'b0;
                w_act_n      = 1'b0;
                w_a          = r_req_row;
                w_bg         = r_req_bg;
                w_ba         = r_req_ba;
                w_tbl_act    = 1'b1;
                w_wait_next  = WaitW'(tRCD - 2);
                w_state_next = StWaitRcd;
            end
            StWaitRcd: begin
                if (r_wait == '0) w_state_next = StCas;
                else              w_wait_next  = r_wait - 1'b1;
            end
            StCas: begin
                w_cs_n                = 1'b0;
                w_a[COLWIDTH-1:0]     = r_req_col;
                w_a[ApBit]            = 1'b0;
                w_a[CmdMsb:CmdLsb]    = r_req_rd ? CmdRd : CmdWr;
                w_bg                  = r_req_bg;
                w_ba                  = r_req_ba;
                w_wait_next           = WaitW'(BL / 2 - 1);
                w_state_next          = StWaitBurst;
            end
            StWaitBurst: begin
                if (r_wait == '0) begin
                    w_cmd_done   = 1'b1;
                    w_state_next = StIdle;
                end else begin
                    w_wait_next  = r_wait - 1'b1;
                end
            end
            StPrea: begin
                if (w_tbl_all_tras_met) begin
                    w_cs_n             = 1'b0;
                    w_a[CmdMsb:CmdLsb] = CmdPre;
                    w_a[ApBit]         = 1'b1;
                    w_tbl_close_all    = 1'b1;
                    w_wait_next        = WaitW'(tRP - 2);
                    w_state_next       = StWaitRpa;
                end
            end
            StWaitRpa: begin
                if (r_wait == '0) w_state_next = StRef;
                else              w_wait_next  = r_wait - 1'b1;
            end
            StRef: begin
                w_cs_n             = 1'b0;
                w_a[CmdMsb:CmdLsb] = CmdRef;
                w_tbl_close_all    = 1'b1;
                w_ref_clear        = 1'b1;
                w_wait_next        = WaitW'(tRFC - 2);
                w_state_next       = StWaitRfc;
            end
            StWaitRfc: begin
                if (r_wait == '0) w_state_next = StIdle;
                else              w_wait_next  = r_wait - 1'b1;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= StIdle;
            r_wait        <= '0;
            r_ref_cnt     <= RefW'(tREFI);
            r_ref_pending <= 1'b0;
            r_req_rd      <= 1'b0;
            r_req_bg      <= '0;
            r_req_ba      <= '0;
            r_req_row     <= '0;
            r_req_col     <= '0;
            r_act_n       <= 1'b1;
            r_cs_n        <= 1'b1;
            r_cke         <= 1'b0;
            r_a           <= '0;
            r_bg          <= '0;
            r_ba          <= '0;
            r_cmd_done    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait     <= w_wait_next;
            r_act_n    <= w_act_n;
            r_cs_n     <= w_cs_n;
            r_cke      <= 1'b1;
            r_a        <= w_a;
            r_bg       <= w_bg;
            r_ba       <= w_ba;
            r_cmd_done <= w_cmd_done;
            if (w_accept) begin
                r_req_rd  <= req_rd_o_wr;
                r_req_bg  <= req_bg;
                r_req_ba  <= req_ba;
                r_req_row <= req_row;
                r_req_col <= req_col;
            end
            r_ref_cnt <= w_ref_due ? RefW'(tREFI) : (r_ref_cnt - 1'b1);
            // A new expiry outranks the clear so a refresh is never lost.
            if (w_ref_due) begin
                r_ref_pending <= 1'b1;
            end else if (w_ref_clear) begin
                r_ref_pending <= 1'b0;
            end
        end
    end

    assign req_ready = w_ready;
    assign cmd_done  = r_cmd_done;
    assign act_n     = r_act_n;
    assign cs_n      = r_cs_n;
    assign cke       = r_cke;
    assign A         = r_a;
    assign bg        = r_bg;
    assign ba        = r_ba;

endmodule

// File: tb/tb_ddr4_cmd_gen.sv
// Directed self-checking bench for ddr4_cmd_gen: command encodings, inter-command gaps,
// page hit/miss/conflict, refresh preemption and mid-sequence reset.
module tb_ddr4_cmd_gen;

    localparam int TRCD  = 4;
    localparam int TRP   = 4;
    localparam int TRAS  = 10;
    localparam int TRFC  = 20;
    localparam int TREFI = 200;
    localparam int BURST = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_rd_o_wr = 1'b0;
    logic [1:0]  req_bg = '0;
    logic [1:0]  req_ba = '0;
    logic [16:0] req_row = '0;
    logic [9:0]  req_col = '0;
    logic        req_ready, cmd_done, act_n, cs_n, cke;
    logic [16:0] A;
    logic [1:0]  bg, ba;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int t_rst = 0;
    int t_act_first = 0;
    int t_act_w = 0;

    ddr4_cmd_gen dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rd_o_wr(req_rd_o_wr),
        .req_bg     (req_bg),
        .req_ba     (req_ba),
        .req_row    (req_row),
        .req_col    (req_col),
        .cmd_done   (cmd_done),
        .act_n      (act_n),
        .cs_n       (cs_n),
        .cke        (cke),
        .A          (A),
        .bg         (bg),
        .ba         (ba)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_cmd(input int maxc, output int t, output logic an,
                            output logic [16:0] a, output logic [1:0] g, output logic [1:0] b);
        t = -1; an = 1'b1; a = '0; g = '0; b = '0;
        for (int i = 0; i < maxc && t < 0; i++) begin
            @(negedge clk);
            if (cs_n === 1'b0) begin
                t = cyc; an = act_n; a = A; g = bg; b = ba;
            end
        end
    endtask

    task automatic wait_done(input int maxc, output int t, output logic rdy);
        t = -1; rdy = 1'b0;
        for (int i = 0; i < maxc && t < 0; i++) begin
            @(negedge clk);
            if (cmd_done === 1'b1) begin
                t = cyc; rdy = req_ready;
            end
        end
    endtask

    task automatic send(input logic rd, input logic [1:0] g, input logic [1:0] b,
                        input logic [16:0] row, input logic [9:0] col, output int t_hs);
        req_rd_o_wr = rd; req_bg = g; req_ba = b; req_row = row; req_col = col;
        req_valid = 1'b1;
        t_hs = -1;
        for (int i = 0; i < 100 && t_hs < 0; i++) begin
            if (req_ready === 1'b1) t_hs = cyc + 1;
            else @(negedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({act_n, cs_n, cke, A, bg, ba, req_ready, cmd_done} !== {3'b110, 17'h0, 6'b0}) begin
            errors++;
            $display("FAIL reset_values: got %b expected %b",
                     {act_n, cs_n, cke, A, bg, ba, req_ready, cmd_done}, {3'b110, 23'h0});
        end
        reset_n = 1'b1;
        t_rst = cyc;
        @(negedge clk);
        checks++;
        if ({cke, req_ready, cs_n, act_n} !== 4'b1111) begin
            errors++;
            $display("FAIL post_reset: got cke/rdy/cs_n/act_n=%b expected 1111",
                     {cke, req_ready, cs_n, act_n});
        end
    endtask

    task automatic test_read_closed();
        int t, tc, td; logic an, rdy; logic [16:0] a; logic [1:0] g, b;
        send(1'b1, 2'd0, 2'd0, 17'h123, 10'h040, t);
        checks++;
        if (t < 0) begin errors++; $display("FAIL rd_accept: got %0d expected >=0", t); end
        wait_cmd(30, tc, an, a, g, b);
        t_act_first = tc;
        checks++;
        if (tc !== t + 1) begin errors++; $display("FAIL act_time: got %0d expected %0d", tc, t + 1); end
        checks++;
        if ({an, a, g, b} !== {1'b0, 17'h123, 4'h0}) begin
            errors++; $display("FAIL act_fields: got %h expected %h", {an, a, g, b}, {1'b0, 17'h123, 4'h0});
        end
        wait_cmd(30, tc, an, a, g, b);
        checks++;
        if (tc !== t + 1 + TRCD) begin
            errors++; $display("FAIL rd_time: got %0d expected %0d", tc, t + 1 + TRCD);
        end
        checks++;
        if ({an, a[16:14], a[10], a[9:0]} !== {1'b1, 3'b101, 1'b0, 10'h040}) begin
            errors++; $display("FAIL rd_fields: got %h expected %h", {an, a}, {1'b1, 3'b101, 14'h040});
        end
        wait_done(30, td, rdy);
        checks++;
        if (td !== tc + BURST) begin errors++; $display("FAIL rd_done: got %0d expected %0d", td, tc + BURST); end
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL rd_done_ready: got %b expected 1", rdy); end
    endtask

    task automatic test_row_hit();
        int t, tc, td; logic an, rdy; logic [16:0] a; logic [1:0] g, b;
        send(1'b1, 2'd0, 2'd0, 17'h123, 10'h040, t);
        wait_cmd(30, tc, an, a, g, b);
        checks++;
        if (tc !== t + 1) begin errors++; $display("FAIL hit_time: got %0d expected %0d", tc, t + 1); end
        checks++;
        if ({an, a[16:14], a[9:0]} !== {1'b1, 3'b101, 10'h040}) begin
            errors++; $display("FAIL hit_fields: got %h expected %h", {an, a}, {1'b1, 3'b101, 14'h040});
        end
        wait_done(30, td, rdy);
        checks++;
        if (td !== t + 1 + BURST) begin
            errors++; $display("FAIL hit_done: got %0d expected %0d", td, t + 1 + BURST);
        end
    endtask

    task automatic test_row_conflict();
        int t, tp, ta, tc, td; logic an, rdy; logic [16:0] a; logic [1:0] g, b;
        send(1'b1, 2'd0, 2'd0, 17'h200, 10'h008, t);
        wait_cmd(30, tp, an, a, g, b);
        checks++;
        if (tp < t_act_first + TRAS) begin
            errors++; $display("FAIL pre_tras: got %0d expected >=%0d", tp, t_act_first + TRAS);
        end
        checks++;
        if ({an, a[16:14], a[10], g, b} !== {1'b1, 3'b010, 1'b0, 4'h0}) begin
            errors++; $display("FAIL pre_fields: got %h expected %h", {an, a, g, b}, {1'b1, 3'b010, 18'h0});
        end
        wait_cmd(30, ta, an, a, g, b);
        checks++;
        if (ta !== tp + TRP) begin errors++; $display("FAIL pre_act_gap: got %0d expected %0d", ta, tp + TRP); end
        checks++;
        if ({an, a} !== {1'b0, 17'h200}) begin
            errors++; $display("FAIL act2_fields: got %h expected %h", {an, a}, {1'b0, 17'h200});
        end
        wait_cmd(30, tc, an, a, g, b);
        checks++;
        if (tc !== ta + TRCD) begin errors++; $display("FAIL rd2_time: got %0d expected %0d", tc, ta + TRCD); end
        checks++;
        if ({an, a[16:14], a[9:0]} !== {1'b1, 3'b101, 10'h008}) begin
            errors++; $display("FAIL rd2_fields: got %h expected %h", {an, a}, {1'b1, 3'b101, 14'h008});
        end
        wait_done(30, td, rdy);
        checks++;
        if (td !== tc + BURST) begin errors++; $display("FAIL rd2_done: got %0d expected %0d", td, tc + BURST); end
    endtask

    task automatic test_write_closed();
        int t, ta, tc, td; logic an, rdy; logic [16:0] a; logic [1:0] g, b;
        send(1'b0, 2'd3, 2'd2, 17'h0AB, 10'h03C, t);
        wait_cmd(30, ta, an, a, g, b);
        t_act_w = ta;
        checks++;
        if ({an, a, g, b} !== {1'b0, 17'h0AB, 2'd3, 2'd2} || ta !== t + 1) begin
            errors++; $display("FAIL wr_act: got %h @%0d expected %h @%0d",
                               {an, a, g, b}, ta, {1'b0, 17'h0AB, 4'hE}, t + 1);
        end
        wait_cmd(30, tc, an, a, g, b);
        checks++;
        if (tc !== ta + TRCD) begin errors++; $display("FAIL wr_time: got %0d expected %0d", tc, ta + TRCD); end
        checks++;
        if ({an, a[16:14], a[10], a[9:0], g, b} !== {1'b1, 3'b100, 1'b0, 10'h03C, 4'hE}) begin
            errors++; $display("FAIL wr_fields: got %h expected %h", {an, a, g, b},
                               {1'b1, 3'b100, 14'h03C, 4'hE});
        end
        wait_done(30, td, rdy);
        checks++;
        if (td !== tc + BURST || rdy !== 1'b1) begin
            errors++; $display("FAIL wr_done: got %0d rdy=%b expected %0d rdy=1", td, rdy, tc + BURST);
        end
    endtask

    task automatic test_back_to_back();
        int t, tp, ta, td; logic an, rdy; logic [16:0] a; logic [1:0] g, b;
        send(1'b1, 2'd3, 2'd2, 17'h0AC, 10'h001, t);
        wait_cmd(30, tp, an, a, g, b);
        checks++;
        if (tp < t_act_w + TRAS || tp < 0) begin
            errors++; $display("FAIL b2b_tras: got %0d expected >=%0d", tp, t_act_w + TRAS);
        end
        checks++;
        if ({an, a[16:14], a[10], g, b} !== {1'b1, 3'b010, 1'b0, 4'hE}) begin
            errors++; $display("FAIL b2b_pre: got %h expected %h", {an, a, g, b}, {1'b1, 3'b010, 18'hE});
        end
        wait_cmd(30, ta, an, a, g, b);
        checks++;
        if (ta !== tp + TRP || {an, a} !== {1'b0, 17'h0AC}) begin
            errors++; $display("FAIL b2b_act: got %h @%0d expected %h @%0d",
                               {an, a}, ta, {1'b0, 17'h0AC}, tp + TRP);
        end
        wait_done(40, td, rdy);
        checks++;
        if (td !== ta + TRCD + BURST) begin
            errors++; $display("FAIL b2b_done: got %0d expected %0d", td, ta + TRCD + BURST);
        end
    endtask

    task automatic test_refresh();
        int t, tp, tr, ta, td; logic an, rdy; logic [16:0] a; logic [1:0] g, b;
        test_reset();
        send(1'b1, 2'd1, 2'd1, 17'h055, 10'h010, t);
        wait_done(40, td, rdy);
        while (cyc < t_rst + TREFI - 2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL ref_ready_before: got %b expected 1", req_ready); end
        @(negedge clk);
        req_rd_o_wr = 1'b1; req_bg = 2'd1; req_ba = 2'd1; req_row = 17'h055; req_col = 10'h010;
        req_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL ref_due_ready: got %b expected 0", req_ready); end
        wait_cmd(30, tp, an, a, g, b);
        checks++;
        if (tp !== t_rst + TREFI + 1) begin
            errors++; $display("FAIL prea_time: got %0d expected %0d", tp, t_rst + TREFI + 1);
        end
        checks++;
        if ({an, a[16:14], a[10]} !== {1'b1, 3'b010, 1'b1}) begin
            errors++; $display("FAIL prea_fields: got %h expected %h", {an, a}, {1'b1, 3'b010, 14'h400});
        end
        wait_cmd(30, tr, an, a, g, b);
        checks++;
        if (tr !== tp + TRP || {an, a[16:14]} !== {1'b1, 3'b001}) begin
            errors++; $display("FAIL ref_cmd: got %h @%0d expected %h @%0d",
                               {an, a}, tr, {1'b1, 3'b001, 14'h0}, tp + TRP);
        end
        t = -1;
        for (int i = 0; i < 60 && t < 0; i++) begin
            if (req_ready === 1'b1) t = cyc + 1;
            else @(negedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (t < 0) begin errors++; $display("FAIL ref_req_accept: got %0d expected >=0", t); end
        wait_cmd(30, ta, an, a, g, b);
        checks++;
        if (ta < tr + TRFC || ta < 0 || {an, a} !== {1'b0, 17'h055}) begin
            errors++; $display("FAIL ref_act: got %h @%0d expected %h @>=%0d",
                               {an, a}, ta, {1'b0, 17'h055}, tr + TRFC);
        end
        wait_done(40, td, rdy);
    endtask

    task automatic test_reset_mid();
        int t, ta, td, n_bad; logic an, rdy; logic [16:0] a; logic [1:0] g, b;
        send(1'b1, 2'd2, 2'd1, 17'h0F0, 10'h020, t);
        wait_cmd(30, ta, an, a, g, b);
        checks++;
        if (ta !== t + 1 || an !== 1'b0) begin
            errors++; $display("FAIL mid_act: got act_n=%b @%0d expected 0 @%0d", an, ta, t + 1);
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({act_n, cs_n, cke, A, bg, ba, req_ready, cmd_done} !== {3'b110, 17'h0, 6'b0}) begin
            errors++;
            $display("FAIL mid_reset_values: got %b expected %b",
                     {act_n, cs_n, cke, A, bg, ba, req_ready, cmd_done}, {3'b110, 23'h0});
        end
        reset_n = 1'b1;
        n_bad = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (cmd_done !== 1'b0 || cs_n !== 1'b1) n_bad++;
        end
        checks++;
        if (n_bad != 0) begin errors++; $display("FAIL mid_no_activity: got %0d expected 0", n_bad); end
        send(1'b1, 2'd2, 2'd1, 17'h0F0, 10'h020, t);
        wait_cmd(30, ta, an, a, g, b);
        checks++;
        if (ta !== t + 1 || {an, a, g, b} !== {1'b0, 17'h0F0, 2'd2, 2'd1}) begin
            errors++; $display("FAIL mid_table_cleared: got %h @%0d expected %h @%0d",
                               {an, a, g, b}, ta, {1'b0, 17'h0F0, 4'h9}, t + 1);
        end
        wait_done(40, td, rdy);
    endtask

    initial begin
        test_reset();
        test_read_closed();
        test_row_hit();
        test_row_conflict();
        test_write_closed();
        test_back_to_back();
        test_refresh();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
